// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers, plus MTHI/MTLO writes.
// Latency: Done pulses WIDTH+1 edges after the accepted Start edge; MTHI/MTLO land at the next edge.
// Backpressure: Busy=1 while an operation runs; Start and MTHI/MTLO are ignored then.
// Ports: clk/rst (async active-high); Start/Op/OperandA/OperandB launch an op;
//   WriteHi/WriteLo/WriteData load HI/LO directly; Hi/Lo results; Busy/Done/DivByZero status.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             WriteHi,
  input  logic             WriteLo,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, nextState;

  logic [1:0]         opReg;       // Op[1]: divide, Op[0]: unsigned
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;        // shifted right each cycle while multiplying
  logic [WIDTH-1:0]   aRaw;        // dividend as issued, returned in HI on divide-by-zero
  logic               signA;
  logic               signB;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic               doneReg;
  logic               dbzReg;

  logic               startSigned;
  logic               startSignA;
  logic               startSignB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     shiftRem;
  logic               remFits;
  logic [WIDTH-1:0]   newRem;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign Hi        = hiReg;
  assign Lo        = loReg;
  assign Busy      = (state != IDLE);
  assign Done      = doneReg;
  assign DivByZero = dbzReg;

  // Signed ops work on magnitudes; signs are reapplied in FIX.
  assign startSigned = ~Op[0];
  assign startSignA  = startSigned & OperandA[WIDTH-1];
  assign startSignB  = startSigned & OperandB[WIDTH-1];

  always_comb begin
    // Multiply step: add the multiplicand into the upper half when the current
    // multiplier bit is set; the carry is kept so the following right shift is exact.
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (bMag[0] ? aMag : {WIDTH{1'b0}})};
    // Restoring divide step: upper half is the partial remainder, the lower half
    // shifts the dividend out MSB first and the quotient bits in LSB first.
    shiftRem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    remFits  = (shiftRem >= {1'b0, bMag});
    newRem   = WIDTH'(shiftRem - {1'b0, bMag});
    product  = (signA ^ signB) ? -acc : acc;
    quot     = (signA ^ signB) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem      = signA ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (Start) nextState = RUN;
      RUN:     if (count == LAST) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opReg   <= 2'b00;
      aMag    <= '0;
      bMag    <= '0;
      aRaw    <= '0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      acc     <= '0;
      count   <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            opReg <= Op;
            aMag  <= startSignA ? -OperandA : OperandA;
            bMag  <= startSignB ? -OperandB : OperandB;
            aRaw  <= OperandA;
            signA <= startSignA;
            signB <= startSignB;
            acc   <= {WIDTH'(0), (startSignA ? -OperandA : OperandA)} & {{WIDTH{1'b0}}, {WIDTH{Op[1]}}};
            count <= '0;
          end else begin
            if (WriteHi) hiReg <= WriteData;
            if (WriteLo) loReg <= WriteData;
          end
        end
        RUN: begin
          count <= count + CW'(1);
          if (!opReg[1]) begin
            acc  <= {mulSum, acc[WIDTH-1:1]};
            bMag <= bMag >> 1;
          end else if (remFits) begin
            acc <= {newRem, acc[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {acc[2*WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          doneReg <= 1'b1;
          if (!opReg[1]) begin
            {hiReg, loReg} <= product;
          end else if (bMag == '0) begin
            hiReg  <= aRaw;
            loReg  <= '1;
            dbzReg <= 1'b1;
          end else begin
            hiReg <= rem;
            loReg <= quot;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: stimulus pushes expected HI/LO/DivByZero and
// Done cycle into a scoreboard; a negedge monitor pops and compares on each Done.
// Direct checks cover reset, ignored Start/MTHI while busy, MTHI/MTLO and abort.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] OperandA = '0;
  logic [W-1:0] OperandB = '0;
  logic         WriteHi = 1'b0;
  logic         WriteLo = 1'b0;
  logic [W-1:0] WriteData = '0;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
  logic         Busy;
  logic         Done;
  logic         DivByZero;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .WriteHi(WriteHi), .WriteLo(WriteLo), .WriteData(WriteData),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           doneCyc;
  } exp_t;

  exp_t sb[$];
  exp_t monE;
  int   nChecks = 0;
  int   nFail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected Done edge: E0 is the next posedge, Done appears after E(W+1).
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dbz = dbz; e.doneCyc = cyc + W + 2;
    sb.push_back(e);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    tick();
    Start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!Done && n < 60) begin
      tick();
      n++;
    end
    if (!Done) begin
      nChecks++;
      nFail++;
      $display("FAIL %s_timeout: Done=%b after %0d cycles, expected 1", name, Done, n);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (Done) begin
        if (sb.size() == 0) begin
          nChecks++;
          nFail++;
          $display("FAIL unexpected_done: Done=1 at cycle %0d, expected no Done", cyc);
        end else begin
          monE = sb.pop_front();
          check("result_hi", 64'(Hi), 64'(monE.hi));
          check("result_lo", 64'(Lo), 64'(monE.lo));
          check("result_dbz", 64'(DivByZero), 64'(monE.dbz));
          check("done_cycle", 64'(cyc), 64'(monE.doneCyc));
        end
      end else if (DivByZero) begin
        check("dbz_without_done", 64'(DivByZero), 64'(0));
      end
    end
  end

  localparam int NV = 11;
  logic [1:0]   vOp [NV] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01};
  logic [W-1:0] vA  [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000000, 32'hFFFFFFF9, 32'h80000000,
                             32'h00000005, 32'hFFFFFFF9, 32'h00000007, 32'h00000064, 32'h80000000,
                             32'h80000000};
  logic [W-1:0] vB  [NV] = '{32'hFFFFFFFF, 32'h00000007, 32'h12345678, 32'h00000002, 32'hFFFFFFFF,
                             32'h00000000, 32'h00000000, 32'hFFFFFFFE, 32'h00000007, 32'h80000000,
                             32'h00000002};
  logic [W-1:0] vHi [NV] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000,
                             32'h00000005, 32'hFFFFFFF9, 32'h00000001, 32'h00000002, 32'h40000000,
                             32'h00000001};
  logic [W-1:0] vLo [NV] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000000, 32'hFFFFFFFD, 32'h80000000,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0000000E, 32'h00000000,
                             32'h00000000};
  logic         vDz [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    #2;
    check("reset_hi", 64'(Hi), 64'(0));
    check("reset_lo", 64'(Lo), 64'(0));
    check("reset_busy", 64'(Busy), 64'(0));
    check("reset_done", 64'(Done), 64'(0));
    check("reset_dbz", 64'(DivByZero), 64'(0));
    tick();
    rst = 1'b0;
    tick();

    // Each op after the first is issued in the Done cycle of the previous one.
    for (int i = 0; i < NV; i++) begin
      issue(vOp[i], vA[i], vB[i], vHi[i], vLo[i], vDz[i]);
      if (i == 0) check("busy_after_start", 64'(Busy), 64'(1));
      waitDone($sformatf("vec%0d", i));
    end
    repeat (3) tick();
    check("hold_hi", 64'(Hi), 64'(32'h00000001));
    check("hold_lo", 64'(Lo), 64'(32'h00000000));

    // MULTU 6*7 with a stray Start and MTHI at cycle 10.
    issue(2'b01, 32'd6, 32'd7, 32'h0, 32'h2A, 1'b0);
    repeat (8) tick();
    Start = 1'b1; Op = 2'b11; OperandA = 32'd1; OperandB = 32'd1;
    WriteHi = 1'b1; WriteData = 32'hAA;
    tick();
    Start = 1'b0; WriteHi = 1'b0;
    check("busy_ignore_hi", 64'(Hi), 64'(32'h00000001));
    check("busy_still", 64'(Busy), 64'(1));
    waitDone("multu_stray");
    tick();
    check("after_stray_hi", 64'(Hi), 64'(0));

    // MTHI+MTLO together in idle.
    WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'hCAFEF00D;
    tick();
    WriteHi = 1'b0; WriteLo = 1'b0;
    check("mthi_both", 64'(Hi), 64'(32'hCAFEF00D));
    check("mtlo_both", 64'(Lo), 64'(32'hCAFEF00D));

    // Start beats MTHI in the same cycle.
    WriteHi = 1'b1; WriteData = 32'h77;
    issue(2'b01, 32'd2, 32'd3, 32'h0, 32'h6, 1'b0);
    WriteHi = 1'b0;
    check("start_wins_hi", 64'(Hi), 64'(32'hCAFEF00D));
    waitDone("start_wins");
    tick();

    // Abort a DIV at cycle 15 with reset; no Done may follow.
    Start = 1'b1; Op = 2'b10; OperandA = 32'hFFFFFFF9; OperandB = 32'd2;
    tick();
    Start = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(Busy), 64'(0));
    check("abort_hi", 64'(Hi), 64'(0));
    check("abort_lo", 64'(Lo), 64'(0));
    check("abort_done", 64'(Done), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    check("post_abort_busy", 64'(Busy), 64'(0));
    WriteLo = 1'b1; WriteData = 32'h1234;
    tick();
    WriteLo = 1'b0;
    check("mtlo_after_abort", 64'(Lo), 64'(32'h1234));
    check("hi_after_mtlo", 64'(Hi), 64'(0));
    repeat (40) tick();
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
